mul_pipe_p: RTL and testbench
=============================

MUL_PIPE_P -- requirements
Module: mul_pipe_p

Interface
REQ-001 Parameter WIDTH, default 16, operand width; SHALL be even, range 8..32.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-003 Port clk, input, 1, the single clock; all state SHALL be on its rising edge.
REQ-004 Port rst, input, 1, reset, asynchronous and active-high.
REQ-005 Port in_valid, input, 1, operand set is presented.
REQ-006 Port in_ready, output, 1, the block accepts an operand set this cycle.
REQ-007 Port in_a, input, WIDTH, multiplicand.
REQ-008 Port in_b, input, WIDTH, multiplier.
REQ-009 Port in_signed, input, 1: 1 means two's-complement operands; 0 means unsigned operands.
REQ-010 Port in_tag, input, TAG_W, sideband tag returned unchanged with the result.
REQ-011 Port out_valid, output, 1, a result is presented.
REQ-012 Port out_ready, input, 1, the consumer takes the result this cycle.
REQ-013 Port out_result, output, 2*WIDTH, the product.
REQ-014 Port out_tag, output, TAG_W, the tag of the presented result.

Function
REQ-015 Acceptance SHALL occur when in_valid&&in_ready; delivery SHALL occur when out_valid&&out_ready.
REQ-016 The pipeline SHALL have three register stages: S1 radix-4 Booth partial products (WIDTH/2+1 rows, 2*WIDTH wide); S2 carry-save compression to a sum/carry pair; S3 final carry-propagate add registered into out_result.
REQ-017 Each stage SHALL hold a valid bit, and its tag and signed flag SHALL travel with the data.
REQ-018 A stage SHALL load when it is empty or when its contents move downstream in the same cycle; otherwise it SHALL hold.
REQ-019 in_ready SHALL equal !S1.valid || S1 advancing, which gives a combinational ready chain back from out_ready.
REQ-020 With out_ready held at 1, out_valid SHALL assert exactly 3 cycles after acceptance, and throughput SHALL be one result per cycle.
REQ-021 While out_valid=1 and out_ready=0, out_result and out_tag SHALL remain stable, and no accepted operation SHALL be lost or duplicated.
REQ-022 Signed mode SHALL sign-extend both operands; unsigned mode SHALL zero-extend them with one extra Booth row, so that the product is exact in 2*WIDTH bits.
REQ-023 Results SHALL be delivered in acceptance order.
REQ-024 Accept and deliver in the same cycle with a full pipeline SHALL be sustained without a bubble.

Reset
REQ-025 While rst=1, all stage valid bits SHALL clear, out_valid=0, out_result=0, out_tag=0, and in_ready=1 (while rst=0 and the pipeline is empty).
REQ-026 Asserting rst mid-operation SHALL discard all in-flight operations, and none SHALL be delivered after reset.

Configuration
REQ-027 Macro MUL_PIPE_ACC_EN: when defined, an input port in_acc (1 bit) SHALL travel with the operation, and S3 SHALL output product + the previous delivered out_result (modulo 2^(2*WIDTH)) when in_acc=1.
REQ-028 When MUL_PIPE_ACC_EN is defined, the accumulator SHALL update only on delivery and SHALL reset to 0.
REQ-029 When MUL_PIPE_ACC_EN is undefined, in_acc SHALL be absent and out_result SHALL be the plain product.

Structure
REQ-030 Package mul_pipe_pkg SHALL hold the Booth digit encoding typedef (0, +1, +2, -1, -2), the row-count function of WIDTH, and the stage record typedef (valid, tag, signed).
REQ-031 One sub-module, booth_row_gen, SHALL produce one partial-product row from a 3-bit Booth window and the extended multiplicand, and it SHALL be instantiated per row.

Verification (WIDTH=16)
REQ-032 Unsigned 0xFFFF*0xFFFF with out_ready=1 -> 0xFFFE0001 exactly 3 cycles later, with the tag echoed.
REQ-033 Signed 0x8000*0x8000 -> 0x40000000; signed 0xFFFF*0x0002 -> 0xFFFFFFFE; unsigned 0xFFFF*0x0002 -> 0x0001FFFE.
REQ-034 Back-to-back stream of 100 random operations with out_ready=1 -> one result per cycle, in order, all matching the reference model.
REQ-035 out_ready=0 for 5 cycles while feeding operations -> in_ready drops after 3 accepts plus the held output, out_result stays stable, and on release all results arrive in order with none lost.
REQ-036 Assert rst with 3 operations in flight -> out_valid=0 next cycle, and no stale result appears afterwards.
REQ-037 (MUL_PIPE_ACC_EN) Sequence 3*4 (acc=0), then 5*6 (acc=1) -> results 12, then 42.

Source files
------------

// File: rtl/mul_pipe_pkg.sv
// Shared types and helpers for the three-stage radix-4 Booth multiplier pipeline.
// Tags wider than MAX_TAG_W are truncated inside the stage record.
package mul_pipe_pkg;

    localparam int MAX_TAG_W = 16;

    typedef enum logic [2:0] {
        BD_ZERO = 3'd0,
        BD_P1   = 3'd1,
        BD_P2   = 3'd2,
        BD_M1   = 3'd3,
        BD_M2   = 3'd4
    } booth_dig_e;

    // Control that travels alongside the datapath of each stage.
    typedef struct packed {
        logic                 valid;
        logic                 sgn;
        logic [MAX_TAG_W-1:0] tag;
    } stage_t;

    // The multiplier is extended by two bits, so one row more than WIDTH/2.
    function automatic int booth_rows(input int width);
        return width / 2 + 1;
    endfunction

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_dig_e booth_enc(input logic [2:0] win);
        case (win)
            3'b001, 3'b010: return BD_P1;
            3'b011:         return BD_P2;
            3'b100:         return BD_M2;
            3'b101, 3'b110: return BD_M1;
            default:        return BD_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mul_pipe_p_booth_row_gen.sv
// One radix-4 Booth partial-product row: digit * multiplicand, shifted to its
// row weight, truncated to 2*WIDTH bits (two's complement wraps are intended).
import mul_pipe_pkg::*;

module booth_row_gen #(
    parameter int WIDTH = 16,
    parameter int ROW   = 0
) (
    input  logic [2:0]         i_win,
    input  logic [2*WIDTH-1:0] i_mcand,
    output logic [2*WIDTH-1:0] o_row
);

    booth_dig_e         w_dig;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_signed;

    assign w_dig = booth_enc(i_win);

    always_comb begin
        w_mag = '0;
        case (w_dig)
            BD_P1, BD_M1: w_mag = i_mcand;
            BD_P2, BD_M2: w_mag = i_mcand << 1;
            default:      w_mag = '0;
        endcase
    end

    assign w_signed = (w_dig == BD_M1 || w_dig == BD_M2) ? -w_mag : w_mag;
    assign o_row    = w_signed << (2 * ROW);

endmodule

// File: rtl/mul_pipe_p.sv
// Three-stage elastic radix-4 Booth multiplier: S1 partial products, S2 carry-save
// compression, S3 final add. Optional accumulate mode under `MUL_PIPE_ACC_EN.
import mul_pipe_pkg::*;

module mul_pipe_p #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    input  logic [TAG_W-1:0]   in_tag,
`ifdef MUL_PIPE_ACC_EN
    input  logic               in_acc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_result,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int ROWS = booth_rows(WIDTH);
    localparam int PW   = 2 * WIDTH;

    stage_t r_s1, r_s2, r_s3, w_in_rec;
    logic   w_s1_en, w_s2_en, w_s3_en;

    logic [ROWS-1:0][PW-1:0] w_pp, r_pp;
    logic [PW-1:0]           w_ax;
    logic [WIDTH+2:0]        w_bx;
    logic                    w_bsx;
    logic [PW-1:0]           w_csa_s, w_csa_c, w_csa_t;
    logic [PW-1:0]           r_sum, r_cry;
    logic [PW-1:0]           w_s3_d, r_res;

    // Ready ripples back from the consumer: a stage takes new data when empty or draining.
    assign w_s3_en  = !r_s3.valid || out_ready;
    assign w_s2_en  = !r_s2.valid || w_s3_en;
    assign w_s1_en  = !r_s1.valid || w_s2_en;
    assign in_ready = w_s1_en;

    always_comb begin
        w_in_rec       = '0;
        w_in_rec.valid = in_valid;
        w_in_rec.sgn   = in_signed;
        w_in_rec.tag   = MAX_TAG_W'(in_tag);
    end

    // Operand extension: the 2-bit multiplier extension gives unsigned mode its extra row.
    assign w_bsx = in_signed & in_b[WIDTH-1];
    assign w_bx  = {{2{w_bsx}}, in_b, 1'b0};
    assign w_ax  = {{WIDTH{in_signed & in_a[WIDTH-1]}}, in_a};

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        booth_row_gen #(
            .WIDTH (WIDTH),
            .ROW   (g)
        ) u_row (
            .i_win   (w_bx[2*g+2:2*g]),
            .i_mcand (w_ax),
            .o_row   (w_pp[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= '0;
            r_pp <= '0;
        end else if (w_s1_en) begin
            r_s1 <= w_in_rec;
            if (in_valid) r_pp <= w_pp;
        end
    end

    // Linear chain of 3:2 compressors; sum + carry equals the row total modulo 2^PW.
    always_comb begin
        w_csa_s = '0;
        w_csa_c = '0;
        w_csa_t = '0;
        for (int r = 0; r < ROWS; r++) begin
            w_csa_t = w_csa_s ^ w_csa_c ^ r_pp[r];
            w_csa_c = ((w_csa_s & w_csa_c) | (w_csa_s & r_pp[r]) | (w_csa_c & r_pp[r])) << 1;
            w_csa_s = w_csa_t;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2  <= '0;
            r_sum <= '0;
            r_cry <= '0;
        end else if (w_s2_en) begin
            r_s2 <= r_s1;
            if (r_s1.valid) begin
                r_sum <= w_csa_s;
                r_cry <= w_csa_c;
            end
        end
    end

`ifdef MUL_PIPE_ACC_EN
    logic r_s1_acc, r_s2_acc;
    logic [PW-1:0] r_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_acc <= 1'b0;
            r_s2_acc <= 1'b0;
            r_acc    <= '0;
        end else begin
            if (w_s1_en) r_s1_acc <= in_acc;
            if (w_s2_en) r_s2_acc <= r_s1_acc;
            if (out_valid && out_ready) r_acc <= r_res;
        end
    end

    // When S3 is occupied it can only reload while delivering, so the
    // previously delivered value is the one on out_result right now.
    always_comb begin
        w_s3_d = r_sum + r_cry;
        if (r_s2_acc) w_s3_d = w_s3_d + (r_s3.valid ? r_res : r_acc);
    end
`else
    always_comb begin
        w_s3_d = r_sum + r_cry;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3  <= '0;
            r_res <= '0;
        end else if (w_s3_en) begin
            r_s3 <= r_s2;
            if (r_s2.valid) r_res <= w_s3_d;
        end
    end

    assign out_valid  = r_s3.valid;
    assign out_result = r_res;
    assign out_tag    = r_s3.tag[TAG_W-1:0];

    logic w_unused;
    assign w_unused = ^{r_s3.sgn, r_s3.tag};

endmodule

// File: tb/tb_mul_pipe_p.sv
// Directed and streamed checks of mul_pipe_p against a queue-based reference model.
module tb_mul_pipe_p;

    localparam int WIDTH = 16;
    localparam int TAG_W = 4;
`ifdef MUL_PIPE_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a = '0;
    logic [WIDTH-1:0]  in_b = '0;
    logic              in_signed = 1'b0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              in_acc = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [2*WIDTH-1:0] out_result;
    logic [TAG_W-1:0]  out_tag;

    mul_pipe_p #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_signed  (in_signed),
        .in_tag     (in_tag),
`ifdef MUL_PIPE_ACC_EN
        .in_acc     (in_acc),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [63:0] pa, pb, p;
        pa = s ? {{48{a[15]}}, a} : {48'd0, a};
        pb = s ? {{48{b[15]}}, b} : {48'd0, b};
        p  = pa * pb;
        return p[31:0];
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    int          last_del = -1000;
    int          n_deliv  = 0;
    logic [31:0] last_exp = '0;

    // Reference model + per-cycle compare: occupancy gives ready, acceptance time
    // and previous delivery give out_valid, the queue gives order and values.
    initial begin
        bit          prev_hold;
        logic [31:0] prev_res;
        logic [3:0]  prev_tag;
        bit          exp_rdy, exp_ov;
        int          t;
        exp_t        e;
        prev_hold = 0;
        prev_res  = '0;
        prev_tag  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                q.delete();
                last_del  = -1000;
                last_exp  = '0;
                prev_hold = 0;
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_result", 64'(out_result), 64'd0);
                chk("rst_out_tag", 64'(out_tag), 64'd0);
            end else begin
                exp_rdy = (q.size() < 3) || out_ready;
                chk("in_ready", 64'(in_ready), 64'(exp_rdy));
                exp_ov = 0;
                if (q.size() > 0) begin
                    t = q[0].cyc + 3;
                    if (last_del + 1 > t) t = last_del + 1;
                    exp_ov = (cyc >= t);
                end
                chk("out_valid", 64'(out_valid), 64'(exp_ov));
                if (out_valid && q.size() > 0) begin
                    chk("out_result", 64'(out_result), 64'(q[0].res));
                    chk("out_tag", 64'(out_tag), 64'(q[0].tag));
                end
                if (prev_hold) begin
                    chk("hold_result", 64'(out_result), 64'(prev_res));
                    chk("hold_tag", 64'(out_tag), 64'(prev_tag));
                end
                prev_hold = out_valid && !out_ready;
                prev_res  = out_result;
                prev_tag  = out_tag;
                if (out_valid && out_ready) begin
                    if (q.size() > 0) void'(q.pop_front());
                    last_del = cyc;
                    n_deliv++;
                end
                if (in_valid && in_ready) begin
                    e.res = ref_mul(in_a, in_b, in_signed) + ((ACC_EN && in_acc) ? last_exp : 32'd0);
                    e.tag = in_tag;
                    e.cyc = cyc;
                    last_exp = e.res;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input logic [3:0] tag, input logic acc);
        int i;
        in_a = a; in_b = b; in_signed = s; in_tag = tag; in_acc = acc;
        in_valid = 1'b1;
        i = 0;
        do begin
            @(negedge clk);
            i++;
        end while (!in_ready && i < 40);
        chk("send_accepted", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic s, input logic [3:0] tag, input logic acc,
                            input logic [31:0] exp);
        send(a, b, s, tag, acc);
        @(negedge clk);
        @(negedge clk);
        chk({nm, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({nm, "_valid"}, 64'(out_valid), 64'd1);
        chk({nm, "_result"}, 64'(out_result), 64'(exp));
        chk({nm, "_tag"}, 64'(out_tag), 64'(tag));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while (q.size() != 0 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc, k, t0, base;
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        directed("u_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 4'h5, 1'b0, 32'hFFFE0001);
        directed("s_8000_8000", 16'h8000, 16'h8000, 1'b1, 4'h6, 1'b0, 32'h40000000);
        directed("s_ffff_0002", 16'hFFFF, 16'h0002, 1'b1, 4'h7, 1'b0, 32'hFFFFFFFE);
        directed("u_ffff_0002", 16'hFFFF, 16'h0002, 1'b0, 4'h8, 1'b0, 32'h0001FFFE);
        directed("s_7fff_8000", 16'h7FFF, 16'h8000, 1'b1, 4'h9, 1'b0, 32'hC0008000);
        directed("s_fffd_0007", 16'hFFFD, 16'h0007, 1'b1, 4'hA, 1'b0, 32'hFFFFFFEB);
        directed("u_0000_beef", 16'h0000, 16'hBEEF, 1'b0, 4'hB, 1'b0, 32'h00000000);

        // Back-to-back random stream.
        base = n_deliv;
        t0   = 0;
        for (int i = 0; i < 100; i++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 4'(i), 1'b0);
            if (i == 0) t0 = cyc - 1;
        end
        wait_drain();
        chk("stream_count", 64'(n_deliv - base), 64'd100);
        chk("stream_last_cycle", 64'(last_del), 64'(t0 + 102));

        // Output stall while feeding.
        out_ready = 1'b0;
        nacc = 0;
        k    = 0;
        for (int c = 0; c < 5; c++) begin
            in_a = 16'(k + 2); in_b = 16'd3; in_signed = 1'b0; in_tag = 4'(k); in_acc = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                nacc++;
                k++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("stall_accepts", 64'(nacc), 64'd3);
        @(negedge clk);
        chk("stall_ready_low", 64'(in_ready), 64'd0);
        chk("stall_held_result", 64'(out_result), 64'd6);
        chk("stall_held_tag", 64'(out_tag), 64'd0);
        @(posedge clk);
        #1;
        base = n_deliv;
        out_ready = 1'b1;
        wait_drain();
        chk("stall_release_count", 64'(n_deliv - base), 64'd3);

        // Reset with operations in flight.
        send(16'd11, 16'd12, 1'b0, 4'h1, 1'b0);
        send(16'd13, 16'd14, 1'b0, 4'h2, 1'b0);
        send(16'd15, 16'd16, 1'b0, 4'h3, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_kill_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = n_deliv;
        repeat (10) @(negedge clk);
        chk("rst_no_stale", 64'(n_deliv - base), 64'd0);
        chk("rst_idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;

`ifdef MUL_PIPE_ACC_EN
        directed("acc_3x4", 16'd3, 16'd4, 1'b0, 4'hC, 1'b0, 32'd12);
        directed("acc_5x6", 16'd5, 16'd6, 1'b0, 4'hD, 1'b1, 32'd42);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
